// File: rtl/uart_tx_arbiter_if.sv
// Requester streams plus the UART send/ready pair shared by uart_tx_arbiter.
// The master side is the arbiter; the slave side is whatever drives the
// requesters and models the transmitter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic               uart_ready;
  logic               uart_send;
  logic [7:0]         uart_data;
  logic [N_REQ-1:0]   grant;
  logic               busy;

  modport master (
    input  req_valid, req_data, req_last, uart_ready,
    output req_ready, uart_send, uart_data, grant, busy
  );

  modport slave (
    output req_valid, req_data, req_last, uart_ready,
    input  req_ready, uart_send, uart_data, grant, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among N_REQ byte
// streams. An owner keeps the UART until its last byte or until MAX_BURST
// bytes have gone out, then the search pointer moves past it.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [N_REQ-1:0]  r_grant;
  logic [PTR_W-1:0]  r_owner;
  logic [PTR_W-1:0]  r_ptr;
  logic [7:0]        r_burstCnt;
  logic              r_lastQ;

  logic              w_found;
  logic [PTR_W-1:0]  w_winner;
  logic [SUM_W-1:0]  w_sum;
  logic [PTR_W-1:0]  w_cand;
  logic              w_send;
  logic              w_release;
  logic [7:0]        w_data;

  // Pick the first valid requester at or after r_ptr, wrapping around; the
  // downward loop lets the closest candidate overwrite farther ones.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(N_REQ)) begin
        w_sum = w_sum - SUM_W'(N_REQ);
      end
      w_cand = w_sum[PTR_W-1:0];
      if (bus.req_valid[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  // Route the owner's byte to the UART data lines.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == PTR_W'(i)) begin
        w_data = bus.req_data[8*i +: 8];
      end
    end
  end

  // Next-state and handshake decode; a send only happens in ISSUE.
  always_comb begin
    w_stateNext = r_state;
    w_send      = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ARB: begin
        if (w_found) begin
          w_stateNext = ISSUE;
        end
      end
      ISSUE: begin
        w_send = bus.req_valid[r_owner] & bus.uart_ready;
        if (w_send) begin
          w_stateNext = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!bus.uart_ready) begin
          w_stateNext = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.uart_ready) begin
          if (r_lastQ || (r_burstCnt == 8'(MAX_BURST))) begin
            w_release   = 1'b1;
            w_stateNext = ARB;
          end else begin
            w_stateNext = ISSUE;
          end
        end
      end
      default: w_stateNext = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Ownership, burst count, last flag and round-robin pointer bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant    <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_burstCnt <= '0;
      r_lastQ    <= 1'b0;
    end else begin
      if ((r_state == ARB) && w_found) begin
        r_owner    <= w_winner;
        r_grant    <= {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
        r_burstCnt <= '0;
      end
      if (w_send) begin
        r_lastQ    <= bus.req_last[r_owner];
        r_burstCnt <= r_burstCnt + 8'd1;
      end
      if (w_release) begin
        r_grant <= '0;
        r_ptr   <= (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
      end
    end
  end

  assign bus.uart_send = w_send;
  assign bus.uart_data = w_data;
  assign bus.req_ready = r_grant & {N_REQ{w_send}};
  assign bus.grant     = r_grant;
  assign bus.busy      = (r_state != ARB);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-backed requesters, a UART timing model,
// and a packet-level round-robin reference that predicts the byte order.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0] grant;
    logic [N-1:0] ready;
    logic [7:0]   data;
  } obs_t;

  typedef struct {
    int         req;
    logic [7:0] data;
  } exp_t;

  logic [8:0] srcQ [N][$];
  logic [8:0] mQ   [N][$];
  obs_t       obsQ [$];
  exp_t       expQ [$];

  int mPtr       = 0;
  int frameCfg   = 3;
  int holdCfg    = 0;
  int uDelay     = 0;
  int uBusy      = 0;
  int protoErr   = 0;
  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Queue one packet on a requester and mirror it into the reference copy.
  task automatic applyStimulus(input int req, input int len, input logic [7:0] first,
                               input bit rnd, input bit withLast);
    logic [8:0] e;
    for (int k = 0; k < len; k++) begin
      e[7:0] = rnd ? 8'($urandom) : first + 8'(k);
      e[8]   = withLast && (k == len - 1);
      srcQ[req].push_back(e);
      mQ[req].push_back(e);
    end
  endtask

  // Grant-level round robin: owner is the first non-empty requester from
  // mPtr, it sends until a last byte or MAXB bytes, then mPtr moves past it.
  task automatic modelRun();
    int         owner;
    int         cnt;
    logic [8:0] e;
    exp_t       x;
    forever begin
      owner = -1;
      for (int k = 0; k < N; k++) begin
        if (owner < 0 && mQ[(mPtr + k) % N].size() > 0) owner = (mPtr + k) % N;
      end
      if (owner < 0) break;
      cnt = 0;
      do begin
        e      = mQ[owner].pop_front();
        x.req  = owner;
        x.data = e[7:0];
        expQ.push_back(x);
        cnt++;
      end while (!e[8] && cnt < MAXB && mQ[owner].size() > 0);
      mPtr = (owner + 1) % N;
    end
  endtask

  task automatic clearQueues();
    for (int i = 0; i < N; i++) begin
      srcQ[i].delete();
      mQ[i].delete();
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    clearQueues();
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    mPtr = 0;
  endtask

  task automatic waitSends(input string tag, input int n, input int budget);
    int cyc = 0;
    while (obsQ.size() < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput(tag, obsQ.size() >= n, 1);
  endtask

  // Run until sources drain and the DUT and UART are idle, then compare the
  // logged sends against the expected sequence.
  task automatic runScenario(input string tag, input int budget);
    int           cyc = 0;
    bit           done = 0;
    bit           anyLeft;
    int           n;
    logic [N-1:0] oh;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      anyLeft = 0;
      for (int i = 0; i < N; i++) if (srcQ[i].size() > 0) anyLeft = 1;
      done = !anyLeft && !bus.busy && uDelay == 0 && uBusy == 0 && bus.uart_ready;
    end
    checkOutput({tag, " drained"}, done, 1);
    if (!done) clearQueues();
    checkOutput({tag, " byte count"}, obsQ.size(), expQ.size());
    n = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      oh = '0;
      oh[expQ[i].req] = 1'b1;
      checkOutput($sformatf("%s byte %0d {grant,ready,data}", tag, i),
                  {obsQ[i].grant, obsQ[i].ready, obsQ[i].data},
                  {oh, oh, expQ[i].data});
    end
    checkOutput({tag, " uart protocol"}, protoErr, 0);
    obsQ.delete();
    expQ.delete();
    protoErr = 0;
  endtask

  // Requester and UART environment: sample outputs mid-cycle, apply their
  // effect just after the clock edge, then drive the next inputs.
  initial begin : driver
    logic         sendS;
    logic [7:0]   dataS;
    logic [N-1:0] readyS;
    logic [N-1:0] grantS;
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic [8*N-1:0] d;
    obs_t         o;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_last   = '0;
    bus.uart_ready = 1'b1;
    forever begin
      @(negedge clk);
      sendS  = bus.uart_send;
      dataS  = bus.uart_data;
      readyS = bus.req_ready;
      grantS = bus.grant;
      @(posedge clk);
      #1;
      if (readyS != '0 && !sendS) protoErr++;
      for (int i = 0; i < N; i++) begin
        if (readyS[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
      end
      if (sendS) begin
        o.grant = grantS;
        o.ready = readyS;
        o.data  = dataS;
        obsQ.push_back(o);
        if (uDelay != 0 || uBusy != 0) protoErr++;
        uDelay = holdCfg;
        uBusy  = frameCfg;
      end else if (uDelay > 0) begin
        uDelay--;
      end else if (uBusy > 0) begin
        uBusy--;
      end
      bus.uart_ready = (uDelay > 0) || (uBusy == 0);
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < N; i++) begin
        if (srcQ[i].size() > 0) begin
          v[i]         = 1'b1;
          d[8*i +: 8]  = srcQ[i][0][7:0];
          l[i]         = srcQ[i][0][8];
        end
      end
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_last  = l;
    end
  end

  initial begin : main
    exp_t x;
    int   np;
    int   len;

    // Reset values while rst is held.
    repeat (2) @(negedge clk);
    checkOutput("reset grant", bus.grant, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset uart_send", bus.uart_send, 0);
    checkOutput("reset req_ready", bus.req_ready, 0);
    rst = 1'b0;

    $display("[TB] single requester packet");
    applyStimulus(2, 3, 8'h41, 0, 1);
    modelRun();
    runScenario("single req2", 500);
    checkOutput("single grant released", bus.grant, 0);
    checkOutput("single busy low", bus.busy, 0);

    $display("[TB] pointer rotation after release");
    applyStimulus(0, 1, 8'h50, 0, 1);
    applyStimulus(3, 1, 8'h53, 0, 1);
    modelRun();
    runScenario("ptr rotation", 500);

    $display("[TB] simultaneous single-byte packets");
    doReset();
    for (int i = 0; i < N; i++) applyStimulus(i, 1, 8'hA0 + 8'(i), 0, 1);
    modelRun();
    runScenario("simultaneous", 500);

    $display("[TB] packet lock across a valid gap");
    applyStimulus(0, 1, 8'h10, 0, 0);
    waitSends("lock first byte", 1, 200);
    applyStimulus(1, 1, 8'h20, 0, 1);
    repeat (50) begin
      @(negedge clk);
      checkOutput("lock grant held", bus.grant, 4'b0001);
    end
    applyStimulus(0, 1, 8'h11, 0, 1);
    for (int i = 0; i < N; i++) mQ[i].delete();
    x.req = 0; x.data = 8'h10; expQ.push_back(x);
    x.req = 0; x.data = 8'h11; expQ.push_back(x);
    x.req = 1; x.data = 8'h20; expQ.push_back(x);
    runScenario("packet lock", 1000);
    mPtr = 2;

    $display("[TB] burst limit forces release");
    doReset();
    applyStimulus(1, 6, 8'h60, 0, 1);
    applyStimulus(3, 2, 8'h70, 0, 1);
    modelRun();
    runScenario("burst limit", 1000);

    $display("[TB] slow uart ready");
    holdCfg = 3;
    applyStimulus(2, 2, 8'h81, 0, 1);
    modelRun();
    runScenario("slow uart", 500);
    holdCfg = 0;

    $display("[TB] randomized rounds");
    for (int r = 0; r < 8; r++) begin
      frameCfg = $urandom_range(1, 6);
      holdCfg  = $urandom_range(0, 2);
      for (int q = 0; q < N; q++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 6);
          applyStimulus(q, len, 8'h00, 1, 1);
        end
      end
      modelRun();
      runScenario($sformatf("random round %0d", r), 3000);
    end
    holdCfg = 0;

    $display("[TB] reset while waiting for the stop bit");
    frameCfg = 20;
    applyStimulus(0, 3, 8'h90, 0, 1);
    waitSends("pre-reset first byte", 1, 200);
    repeat (3) @(negedge clk);
    checkOutput("pre-reset busy", bus.busy, 1);
    clearQueues();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset grant", bus.grant, 0);
    checkOutput("mid reset busy", bus.busy, 0);
    checkOutput("mid reset uart_send", bus.uart_send, 0);
    checkOutput("mid reset req_ready", bus.req_ready, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("no send after reset", obsQ.size(), 1);
    checkOutput("mid reset uart protocol", protoErr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART byte transmitter among N_REQ requesters using round-robin arbitration with packet locking.
- Each requester presents bytes on a valid/ready stream with a last flag. A granted requester keeps the transmitter until its last byte, or until MAX_BURST bytes have been sent.
- Sits between debug/telemetry sources and the UART; drives the UART's send/data pair and watches its ready output.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  N_REQ  per-requester byte available.
- req_data  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- req_last  input  N_REQ  per-requester flag: current byte ends the packet.
- req_ready  output  N_REQ  per-requester byte accepted this cycle (one-hot or zero).
- uart_ready  input  1  transmitter idle (high = can accept a byte).
- uart_send  output  1  one-cycle request to the transmitter to load uart_data.
- uart_data  output  8  byte to transmit.
- grant  output  N_REQ  registered one-hot owner; zero when no owner.
- busy  output  1  high whenever the state is not ARB.

Behaviour:
- States: ARB, ISSUE, WAIT_BUSY, WAIT_DONE.
- Reset: state ARB, grant 0, rr pointer 0, burst count 0, busy 0. uart_send and req_ready are 0 in ARB, so they are 0 out of reset.
- Reset mid-operation: abandons any packet immediately and does not wait for the UART. The byte already inside the UART still completes on the line.
- ARB:
  - Search req_valid starting at index ptr, wrapping modulo N_REQ. The first set bit becomes the owner.
  - Register grant = one-hot(owner), clear burst count, go to ISSUE next cycle.
  - No valid bit set: stay in ARB.
  - Arbitration costs 1 cycle.
- ISSUE:
  - Combinational: uart_data = req_data slice of the owner.
  - Combinational: uart_send = req_valid[owner] & uart_ready.
  - Combinational: req_ready[owner] = uart_send. All other req_ready bits are 0.
  - On uart_send: capture req_last[owner] into last_q, increment burst count, go to WAIT_BUSY.
  - Owner valid low: stay in ISSUE holding the grant (packet lock). No timeout.
- WAIT_BUSY:
  - Wait for uart_ready low, confirming the UART accepted the byte.
  - uart_ready is expected low on the first cycle; if it stays high the block keeps waiting and never re-sends.
- WAIT_DONE:
  - Wait for uart_ready high (stop bit finished).
  - Then, if last_q = 1 or burst count = MAX_BURST: grant <= 0, ptr <= (owner+1) mod N_REQ, go to ARB.
  - Otherwise return to ISSUE with the same owner.
- Exactly one uart_send pulse per byte. uart_send never asserts outside ISSUE.
- Per-byte overhead: ISSUE to next ISSUE = UART frame time plus at most 2 cycles.
- Simultaneous requests are resolved purely by ptr; fairness means each requester waits at most N_REQ-1 grants.
- req_last is sampled only on the accept cycle. A non-owner's req_last is ignored.
- Burst count is 8 bits wide and compared for equality with MAX_BURST. It resets on every new grant.
- A forced release at MAX_BURST rotates ptr like a normal release. The interrupted requester continues its packet on its next grant.
- req_valid dropping in WAIT_BUSY or WAIT_DONE has no effect; the byte was already consumed.

Test Plan:
- Reset, then a single requester: req 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43) → exactly 3 uart_send pulses in order, grant = 0100 throughout, then grant = 0000, ptr = 3, busy falls.
- Simultaneous packets: all four requesters assert 1-byte packets on the same cycle after reset → grant order 0,1,2,3; uart_data sequence matches each req_data; no byte is lost or duplicated.
- Packet lock: req 0 sends 0x10, drops valid for 50 cycles, then sends 0x11 with last while req 1 is valid → req 1 is not granted until 0x11 completes.
- Burst limit: MAX_BURST = 4, req 1 streams 6 bytes with last on byte 6 while req 3 is valid → 4 bytes from req 1, then req 3's packet, then req 1's remaining 2.
- Slow UART: uart_ready held high for 3 cycles after uart_send → no second pulse; the block proceeds only after ready goes low then high.
- Reset asserted during WAIT_DONE → next cycle grant = 0, busy = 0, state ARB, uart_send = 0.
